// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the load/store unit: memory access sizes, FSM states
// and enable/disable constants.
package mem_access_unit_pkg;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;
  localparam logic [1:0] MEM_RSVD = 2'b11;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10,
    ST_ERR  = 2'b11
  } mau_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: byte enables, store-data replication, load lane
// extraction with sign/zero extension, and the alignment check.
import mem_access_unit_pkg::*;

module mem_lane_align (
  input  logic [1:0]  mem_type,
  input  logic        mem_sign,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] bus_rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);

  logic [7:0]  b_sel;
  logic [15:0] h_sel;

  always_comb begin
    b_sel      = bus_rdata[{addr_lo, 3'b000} +: 8];
    h_sel      = addr_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    be         = 4'b0000;
    wdata_rep  = wdata;
    rdata_ext  = bus_rdata;
    misaligned = 1'b0;
    case (mem_type)
      MEM_BYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{~mem_sign & b_sel[7]}}, b_sel};
      end
      MEM_HALF: begin
        be         = 4'b0011 << addr_lo;
        wdata_rep  = {2{wdata[15:0]}};
        rdata_ext  = {{16{~mem_sign & h_sel[15]}}, h_sel};
        misaligned = addr_lo[0];
      end
      MEM_WORD: begin
        be         = 4'b1111;
        misaligned = (addr_lo != 2'b00);
      end
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: turns one decoded memory op into a word-aligned req/ack bus
// transaction. Build with MAU_TIMEOUT_EN to abort requests left unacknowledged.
import mem_access_unit_pkg::*;

module mem_access_unit #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              rmem,
  input  logic              wmem,
  input  logic [1:0]        mem_type,
  input  logic              mem_sign,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic              busy,
  output logic              misalign,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              bus_err,
  output mau_state_e        dbg_state
);

  // The counter is 8 bits wide, so the abort threshold must fit in it.
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout_cfg
    $error("TIMEOUT_CYC must be in 1..255");
  end

  // Bus handshake: bus_req rises with bus_addr/we/be/wdata valid and they hold
  // unchanged until a cycle in which bus_ack is sampled high; bus_rdata is only
  // looked at in that same cycle, and bus_req drops on the following cycle.
  mau_state_e        state, state_n;
  logic              bus_req_n, bus_we_n, done_n, busy_n, misalign_n, bus_err_n;
  logic [ADDR_W-1:0] bus_addr_n;
  logic [3:0]        bus_be_n;
  logic [DATA_W-1:0] bus_wdata_n, rdata_n;
  logic [1:0]        cap_type, cap_type_n, cap_lane, cap_lane_n;
  logic              cap_sign, cap_sign_n;

  logic [1:0]  la_type, la_lane;
  logic        la_sign, la_mis;
  logic [3:0]  la_be;
  logic [31:0] la_wdata, la_rdata;

  // Live decoder inputs drive the lanes while idle; the captured copies take
  // over once a request is outstanding so the load extraction stays stable.
  assign la_type = (state == ST_IDLE) ? mem_type  : cap_type;
  assign la_sign = (state == ST_IDLE) ? mem_sign  : cap_sign;
  assign la_lane = (state == ST_IDLE) ? addr[1:0] : cap_lane;

  mem_lane_align u_lane (
    .mem_type   (la_type),
    .mem_sign   (la_sign),
    .addr_lo    (la_lane),
    .wdata      (wdata),
    .bus_rdata  (bus_rdata),
    .be         (la_be),
    .wdata_rep  (la_wdata),
    .rdata_ext  (la_rdata),
    .misaligned (la_mis)
  );

`ifdef MAU_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] tmo_cnt, tmo_cnt_n;
`endif

  always_comb begin
    state_n     = state;
    bus_req_n   = bus_req;
    bus_we_n    = bus_we;
    bus_addr_n  = bus_addr;
    bus_be_n    = bus_be;
    bus_wdata_n = bus_wdata;
    rdata_n     = rdata;
    cap_type_n  = cap_type;
    cap_sign_n  = cap_sign;
    cap_lane_n  = cap_lane;
    done_n      = 1'b0;
    misalign_n  = 1'b0;
    bus_err_n   = 1'b0;
`ifdef MAU_TIMEOUT_EN
    tmo_cnt_n   = tmo_cnt;
`endif
    case (state)
      ST_IDLE: begin
        if (start && (rmem || wmem)) begin
          if ((rmem && wmem) || la_mis) begin
            state_n    = ST_ERR;
            done_n     = 1'b1;
            misalign_n = 1'b1;
          end else begin
            state_n     = ST_REQ;
            bus_req_n   = ENABLE;
            bus_we_n    = wmem;
            bus_addr_n  = {addr[ADDR_W-1:2], 2'b00};
            bus_be_n    = la_be;
            bus_wdata_n = la_wdata;
            cap_type_n  = mem_type;
            cap_sign_n  = mem_sign;
            cap_lane_n  = addr[1:0];
`ifdef MAU_TIMEOUT_EN
            tmo_cnt_n   = 8'd0;
`endif
          end
        end
      end
      ST_REQ: begin
        if (bus_ack) begin
          state_n   = ST_DONE;
          bus_req_n = DISABLE;
          done_n    = 1'b1;
          if (!bus_we) rdata_n = la_rdata;
        end
`ifdef MAU_TIMEOUT_EN
        else if (tmo_cnt == TMO_LAST) begin
          state_n   = ST_DONE;
          bus_req_n = DISABLE;
          done_n    = 1'b1;
          bus_err_n = 1'b1;
        end else begin
          tmo_cnt_n = tmo_cnt + 8'd1;
        end
`endif
      end
      ST_DONE: state_n = ST_IDLE;
      ST_ERR:  state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
    busy_n = (state_n != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= 4'b0000;
      bus_wdata <= '0;
      rdata     <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      misalign  <= 1'b0;
      bus_err   <= 1'b0;
      cap_type  <= MEM_BYTE;
      cap_sign  <= 1'b0;
      cap_lane  <= 2'b00;
`ifdef MAU_TIMEOUT_EN
      tmo_cnt   <= 8'd0;
`endif
    end else begin
      state     <= state_n;
      bus_req   <= bus_req_n;
      bus_we    <= bus_we_n;
      bus_addr  <= bus_addr_n;
      bus_be    <= bus_be_n;
      bus_wdata <= bus_wdata_n;
      rdata     <= rdata_n;
      done      <= done_n;
      busy      <= busy_n;
      misalign  <= misalign_n;
      bus_err   <= bus_err_n;
      cap_type  <= cap_type_n;
      cap_sign  <= cap_sign_n;
      cap_lane  <= cap_lane_n;
`ifdef MAU_TIMEOUT_EN
      tmo_cnt   <= tmo_cnt_n;
`endif
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table of loads/stores plus
// hand sequences for reset, ignored starts and the stalled-request cases.
import mem_access_unit_pkg::*;

module tb_mem_access_unit;

  logic        clk, rstn, start, rmem, wmem, mem_sign, bus_ack;
  logic [1:0]  mem_type;
  logic [31:0] addr, wdata, bus_rdata;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic        done, busy, misalign, bus_req, bus_we, bus_err;
  logic [3:0]  bus_be;
  mau_state_e  dbg_state;

  mem_access_unit dut (
    .clk(clk), .rstn(rstn), .start(start), .rmem(rmem), .wmem(wmem),
    .mem_type(mem_type), .mem_sign(mem_sign), .addr(addr), .wdata(wdata),
    .rdata(rdata), .done(done), .busy(busy), .misalign(misalign),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .bus_err(bus_err), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rmem;
    logic        wmem;
    logic [1:0]  mtype;
    logic        msign;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd_in;
    int          ack_dly;
    logic        exp_mis;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[15];
  vec_t sw_vec;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_start(input logic r, input logic w, input logic [1:0] t,
                             input logic s, input logic [31:0] a, input logic [31:0] d);
    start = 1'b1; rmem = r; wmem = w; mem_type = t; mem_sign = s; addr = a; wdata = d;
    tick();
    start = 1'b0; rmem = 1'b0; wmem = 1'b0;
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    drive_start(v.rmem, v.wmem, v.mtype, v.msign, v.addr, v.wdata);
    if (v.exp_mis) begin
      check({nm, ".done"}, {31'b0, done}, 32'd1);
      check({nm, ".misalign"}, {31'b0, misalign}, 32'd1);
      check({nm, ".bus_req"}, {31'b0, bus_req}, 32'd0);
      check({nm, ".rdata"}, rdata, model_rdata);
      tick();
      check({nm, ".busy_after"}, {31'b0, busy}, 32'd0);
      check({nm, ".done_after"}, {31'b0, done}, 32'd0);
    end else begin
      if (v.rmem) exp_q.push_back(v.exp_rdata);
      check({nm, ".bus_req"}, {31'b0, bus_req}, 32'd1);
      check({nm, ".busy"}, {31'b0, busy}, 32'd1);
      check({nm, ".bus_addr"}, bus_addr, v.exp_addr);
      check({nm, ".bus_be"}, {28'b0, bus_be}, {28'b0, v.exp_be});
      check({nm, ".bus_we"}, {31'b0, bus_we}, {31'b0, v.wmem});
      check({nm, ".bus_wdata"}, bus_wdata, v.exp_wdata);
      for (int i = 0; i < v.ack_dly; i++) begin
        tick();
        check($sformatf("%s.req_hold%0d", nm, i), {31'b0, bus_req}, 32'd1);
        check($sformatf("%s.addr_hold%0d", nm, i), bus_addr, v.exp_addr);
      end
      bus_ack = 1'b1; bus_rdata = v.rd_in;
      tick();
      bus_ack = 1'b0; bus_rdata = 32'h0;
      check({nm, ".done"}, {31'b0, done}, 32'd1);
      check({nm, ".req_drop"}, {31'b0, bus_req}, 32'd0);
      check({nm, ".misalign"}, {31'b0, misalign}, 32'd0);
      check({nm, ".bus_err"}, {31'b0, bus_err}, 32'd0);
      if (v.rmem) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL %s.queue: got empty expected entry", nm);
        end else begin
          model_rdata = exp_q.pop_front();
        end
      end
      check({nm, ".rdata"}, rdata, model_rdata);
      tick();
      check({nm, ".done_after"}, {31'b0, done}, 32'd0);
      check({nm, ".busy_after"}, {31'b0, busy}, 32'd0);
    end
  endtask

  initial begin
    //          rd wr type   sg addr          wdata         rd_in        dly mis exp_addr      be       exp_wdata     exp_rdata
    vecs[0]  = '{1, 0, MEM_BYTE, 0, 32'h0000_1003, 32'h0,        32'h80FF_1234, 0, 0, 32'h0000_1000, 4'b1000, 32'h0,        32'hFFFF_FF80};
    vecs[1]  = '{1, 0, MEM_HALF, 1, 32'h0000_2002, 32'h0,        32'h8765_4321, 3, 0, 32'h0000_2000, 4'b1100, 32'h0,        32'h0000_8765};
    vecs[2]  = '{0, 1, MEM_BYTE, 0, 32'h0000_0010, 32'h1234_56AB, 32'h0,        1, 0, 32'h0000_0010, 4'b0001, 32'hABAB_ABAB, 32'h0};
    vecs[3]  = '{0, 1, MEM_HALF, 0, 32'h0000_0012, 32'h1234_56AB, 32'h0,        0, 0, 32'h0000_0010, 4'b1100, 32'h56AB_56AB, 32'h0};
    vecs[4]  = '{1, 0, MEM_WORD, 0, 32'h0000_0006, 32'h0,        32'h0,        0, 1, 32'h0,        4'b0000, 32'h0,        32'h0};
    vecs[5]  = '{1, 0, MEM_HALF, 0, 32'h0000_0001, 32'h0,        32'h0,        0, 1, 32'h0,        4'b0000, 32'h0,        32'h0};
    vecs[6]  = '{1, 0, MEM_BYTE, 1, 32'h0000_0001, 32'h0,        32'h0000_A500, 0, 0, 32'h0000_0000, 4'b0010, 32'h0,        32'h0000_00A5};
    vecs[7]  = '{1, 0, MEM_HALF, 0, 32'h0000_0000, 32'h0,        32'h1234_F00D, 1, 0, 32'h0000_0000, 4'b0011, 32'h0,        32'hFFFF_F00D};
    vecs[8]  = '{1, 0, MEM_WORD, 0, 32'h0000_0004, 32'h0,        32'hDEAD_BEEF, 2, 0, 32'h0000_0004, 4'b1111, 32'h0,        32'hDEAD_BEEF};
    vecs[9]  = '{0, 1, MEM_WORD, 0, 32'h0000_0008, 32'hCAFE_F00D, 32'h0,        0, 0, 32'h0000_0008, 4'b1111, 32'hCAFE_F00D, 32'h0};
    vecs[10] = '{1, 0, MEM_RSVD, 0, 32'h0000_0000, 32'h0,        32'h0,        0, 1, 32'h0,        4'b0000, 32'h0,        32'h0};
    vecs[11] = '{1, 1, MEM_WORD, 0, 32'h0000_0000, 32'h0,        32'h0,        0, 1, 32'h0,        4'b0000, 32'h0,        32'h0};
    vecs[12] = '{1, 0, MEM_BYTE, 1, 32'h0000_3002, 32'h0,        32'h00FF_0000, 0, 0, 32'h0000_3000, 4'b0100, 32'h0,        32'h0000_00FF};
    vecs[13] = '{1, 0, MEM_BYTE, 0, 32'h0000_0000, 32'h0,        32'h0000_007F, 0, 0, 32'h0000_0000, 4'b0001, 32'h0,        32'h0000_007F};
    vecs[14] = '{1, 0, MEM_HALF, 0, 32'h0000_0002, 32'h0,        32'h7FFF_8000, 0, 0, 32'h0000_0000, 4'b1100, 32'h0,        32'h0000_7FFF};
    sw_vec   = '{0, 1, MEM_WORD, 0, 32'h0000_0020, 32'h0BAD_F00D, 32'h0,        1, 0, 32'h0000_0020, 4'b1111, 32'h0BAD_F00D, 32'h0};

    rstn = 1'b0; start = 1'b0; rmem = 1'b0; wmem = 1'b0; mem_type = 2'b00;
    mem_sign = 1'b0; addr = 32'h0; wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
    model_rdata = 32'h0;
    #12;
    check("rst.bus_req", {31'b0, bus_req}, 32'd0);
    check("rst.busy", {31'b0, busy}, 32'd0);
    check("rst.done", {31'b0, done}, 32'd0);
    check("rst.misalign", {31'b0, misalign}, 32'd0);
    check("rst.bus_err", {31'b0, bus_err}, 32'd0);
    check("rst.rdata", rdata, 32'h0);
    check("rst.bus_addr", bus_addr, 32'h0);
    check("rst.bus_be", {28'b0, bus_be}, 32'h0);
    check("rst.state", {30'b0, dbg_state}, {30'b0, ST_IDLE});
    @(negedge clk);
    rstn = 1'b1;
    tick();

    for (int i = 0; i < 15; i++) run_vec($sformatf("v%0d", i), vecs[i]);

    // start with neither rmem nor wmem, and a stray ack while idle
    drive_start(1'b0, 1'b0, MEM_WORD, 1'b0, 32'h40, 32'h0);
    check("nop.busy", {31'b0, busy}, 32'd0);
    check("nop.bus_req", {31'b0, bus_req}, 32'd0);
    check("nop.done", {31'b0, done}, 32'd0);
    bus_ack = 1'b1; bus_rdata = 32'h5555_5555;
    tick();
    bus_ack = 1'b0; bus_rdata = 32'h0;
    check("idle_ack.done", {31'b0, done}, 32'd0);
    check("idle_ack.rdata", rdata, model_rdata);

    // start while busy must not disturb the outstanding request
    drive_start(1'b1, 1'b0, MEM_WORD, 1'b0, 32'h100, 32'h0);
    check("busy_start.state", {30'b0, dbg_state}, {30'b0, ST_REQ});
    drive_start(1'b0, 1'b1, MEM_BYTE, 1'b0, 32'h201, 32'hFFFF_FFFF);
    check("busy_start.bus_addr", bus_addr, 32'h100);
    check("busy_start.bus_we", {31'b0, bus_we}, 32'd0);
    check("busy_start.bus_be", {28'b0, bus_be}, 32'hF);
    bus_ack = 1'b1; bus_rdata = 32'h0102_0304;
    tick();
    bus_ack = 1'b0; bus_rdata = 32'h0;
    model_rdata = 32'h0102_0304;
    check("busy_start.done", {31'b0, done}, 32'd1);
    check("busy_start.rdata", rdata, model_rdata);
    tick();
    tick();
    check("busy_start.no_extra_req", {31'b0, bus_req}, 32'd0);

    // reset in REQ: bus_req falls without a clock, no done afterwards
    drive_start(1'b1, 1'b0, MEM_WORD, 1'b0, 32'h40, 32'h0);
    check("mid_rst.req_before", {31'b0, bus_req}, 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    check("mid_rst.req_async", {31'b0, bus_req}, 32'd0);
    check("mid_rst.busy", {31'b0, busy}, 32'd0);
    model_rdata = 32'h0;
    tick();
    check("mid_rst.done", {31'b0, done}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    tick();
    check("mid_rst.done_after", {31'b0, done}, 32'd0);
    check("mid_rst.rdata", rdata, 32'h0);
    run_vec("sw_after_rst", sw_vec);

`ifdef MAU_TIMEOUT_EN
    begin
      int n_req = 0;
      drive_start(1'b1, 1'b0, MEM_WORD, 1'b0, 32'h0, 32'h0);
      while (bus_req && n_req < 40) begin
        n_req++;
        tick();
      end
      check("tmo.req_cycles", n_req, 32'd16);
      check("tmo.done", {31'b0, done}, 32'd1);
      check("tmo.bus_err", {31'b0, bus_err}, 32'd1);
      check("tmo.rdata", rdata, model_rdata);
      tick();
      check("tmo.busy_after", {31'b0, busy}, 32'd0);
      check("tmo.err_after", {31'b0, bus_err}, 32'd0);
    end
`else
    drive_start(1'b1, 1'b0, MEM_WORD, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 30; i++) tick();
    check("stall.bus_req", {31'b0, bus_req}, 32'd1);
    check("stall.bus_err", {31'b0, bus_err}, 32'd0);
    check("stall.done", {31'b0, done}, 32'd0);
    bus_ack = 1'b1; bus_rdata = 32'h1122_3344;
    tick();
    bus_ack = 1'b0; bus_rdata = 32'h0;
    model_rdata = 32'h1122_3344;
    check("stall.done_ack", {31'b0, done}, 32'd1);
    check("stall.rdata", rdata, model_rdata);
    tick();
`endif

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store execution unit; the consumer of the decoder's memory-control outputs (rmem, wmem, mem_type, mem_sign).
- Converts one decoded load/store into a single word-aligned bus transaction with a req/ack handshake.
  - Stores: byte-enable generation and write-data lane replication.
  - Loads: lane extraction and sign/zero extension.
- Holds the core via busy until the access completes.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, data width; fixed at 32 (4 byte lanes).
- TIMEOUT_CYC, 16, cycles allowed in REQ before abort; used only with MAU_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rstn  in  1  async active-low reset
- start  in  1  one-cycle pulse; MEM stage entered for the current instruction
- rmem  in  1  load instruction
- wmem  in  1  store instruction
- mem_type  in  2  00 byte, 01 half, 10 word, 11 reserved
- mem_sign  in  1  func3[2]: 0 = sign-extend, 1 = zero-extend (loads only)
- addr  in  ADDR_W  effective byte address (rs1+imm)
- wdata  in  32  rs2 store data
- rdata  out  32  extended load result, valid when done=1 and rmem was set
- done  out  1  one-cycle completion pulse
- busy  out  1  access in progress; drives core hold
- misalign  out  1  one-cycle error pulse, coincident with done
- bus_req  out  1  bus request
- bus_we  out  1  1 = write
- bus_addr  out  ADDR_W  word-aligned address, {addr[ADDR_W-1:2],2'b00}
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated write data
- bus_ack  in  1  bus completion
- bus_rdata  in  32  read word, valid with bus_ack
- bus_err  out  1  timeout pulse (MAU_TIMEOUT_EN only; tied 0 otherwise)

Behaviour:
- Reset: rstn is asynchronous, active-low; clock is clk. All outputs reset to 0 and the FSM goes to IDLE. Reset asserted mid-transaction drops bus_req immediately, with no completion pulse.
- All outputs are registered.
- FSM states: IDLE, REQ, DONE, ERR.
- IDLE:
  - start & (rmem^wmem) & aligned: capture bus_addr, bus_we, bus_be, bus_wdata, lane, type and sign; go to REQ.
  - start & (rmem^wmem) & misaligned: go to ERR.
  - start & rmem & wmem: go to ERR.
  - start with neither rmem nor wmem: ignored.
- Alignment:
  - Half requires addr[0]=0.
  - Word requires addr[1:0]=0.
  - mem_type=11 is always misaligned.
- REQ:
  - bus_req=1; bus_addr, bus_we, bus_be and bus_wdata stay stable until ack.
  - On bus_ack: latch the extended rdata (loads only; stores leave rdata unchanged); go to DONE.
  - bus_ack is sampled only in REQ and ignored in all other states.
- DONE: done=1 for one cycle, bus_req=0; return to IDLE.
- ERR: done=1 and misalign=1 for one cycle, no bus activity; return to IDLE.
- busy: 1 whenever state != IDLE. start while busy is ignored.
- Latency: start at cycle N, bus_req at N+1. With ack at N+1, done at N+2; minimum 2 cycles start-to-done. A misaligned access gives done at N+1.
- Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
- Write data: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
- Read data:
  - Select the lane from bus_rdata by the captured addr[1:0] (byte) or addr[1] (half).
  - mem_sign=0 replicates the MSB of the selected byte/half; mem_sign=1 fills with zeros.
  - A word load passes bus_rdata unchanged.

Optional Feature:
- MAU_TIMEOUT_EN defined:
  - An 8-bit counter clears on entering REQ and increments each REQ cycle.
  - When it reaches TIMEOUT_CYC without ack: drop bus_req and go to DONE with bus_err=1 coincident with done. rdata is unchanged.
  - An ack arriving on the same cycle as the timeout wins; it completes normally.
- MAU_TIMEOUT_EN undefined: no counter; REQ waits indefinitely; bus_err tied 0.

Decomposition:
- Shared defines file:
  - mem_type encodings (MEM_BYTE=2'b00, MEM_HALF=2'b01, MEM_WORD=2'b10).
  - FSM state encodings.
  - Enable/Disable constants, alongside the existing decoder macros.
- Sub-module mem_lane_align (purely combinational):
  - Inputs: type, sign, addr[1:0], wdata, bus_rdata.
  - Outputs: be, replicated wdata, extended rdata, misaligned flag.
- The FSM and handshake registers stay in mem_access_unit.

Test Plan:
- LB, addr=0x1003, mem_sign=0, bus_rdata=0x80FF_1234, ack on first REQ cycle -> bus_addr=0x1000, bus_be=0001<<3=1000, rdata=0xFFFF_FF80, done 2 cycles after start.
- LHU, addr=0x2002, bus_rdata=0x8765_4321, ack after 3 wait cycles -> bus_be=1100, rdata=0x0000_8765, bus_req held high 4 cycles with stable bus_addr.
- SB, addr=0x10, wdata=0x1234_56AB -> bus_we=1, bus_be=0001, bus_wdata=0xABAB_ABAB; SH addr=0x12 -> bus_be=1100, bus_wdata=0x56AB_56AB.
- LW, addr=0x06 -> no bus_req, done=1 and misalign=1 one cycle after start, busy deasserted the following cycle.
- Load in REQ, rstn pulsed low before ack -> bus_req falls asynchronously, no done; a subsequent SW to 0x20 completes normally.
- MAU_TIMEOUT_EN, TIMEOUT_CYC=16, no ack -> bus_req falls after 16 REQ cycles, done=1 and bus_err=1 together.
